segre_main_memory: RTL and testbench
====================================

# segre_main_memory

Behavioural lane-wide main-memory model sitting directly downstream of `segre_mmu`, on the `mm_*` side of the cache subsystem. It serves one whole-lane read or write at a time, with a fixed, parameterised latency. It returns completion through a one-cycle ready pulse, which `segre_mmu` consumes as `mm_data_rdy_i` / `mm_data_i`. It is the backing store used by cache-subsystem benches and by full-core simulation.

## Interface
- `ADDR_SIZE`, default 32: address width, matching `segre_pkg::ADDR_SIZE`.
- `LANE_SIZE`, default 128: lane width in bits, equal to `DCACHE_LANE_SIZE`.
- `MEM_LANES`, default 1024: number of lanes stored; must be a power of two.
- `LATENCY`, default 5: number of edges from request accept to response; must be ≥ 1.
- `clk_i` input 1: clock.
- `rsn_i` input 1: reset, asynchronous, active-low.
- `rd_req_i` input 1: read request, driven by `mm_rd_req_o`.
- `wr_req_i` input 1: write request, driven by `mm_wr_req_o`.
- `addr_i` input ADDR_SIZE: byte address, driven by `mm_addr_o`.
- `data_i` input LANE_SIZE: write lane, driven by `mm_data_o`.
- `data_rdy_o` output 1: one-cycle completion pulse for reads and writes, driving `mm_data_rdy_i`.
- `data_o` output LANE_SIZE: read lane, driving `mm_data_i`.
- `busy_o` output 1: high when a transaction is in flight (state ≠ IDLE).

## Operation
- **Storage**
  - `MEM_LANES` × `LANE_SIZE` array.
  - Contents are not affected by reset; they start as X unless the bench preloads them hierarchically.
- **Address decode**
  - Lane index = `addr_i[OFF +: IDX]`, where OFF = log2(LANE_SIZE/8) and IDX = log2(MEM_LANES).
  - Byte-offset bits are ignored.
  - Address bits above OFF+IDX are ignored, so accesses wrap modulo `MEM_LANES`.
- **States:** IDLE, WAIT, RESP. There is also a down-counter `cnt` of width clog2(LATENCY)+1.
- **IDLE**
  - If `wr_req_i` or `rd_req_i` is high at the edge:
    - latch the op (write if `wr_req_i`, else read), the lane index and `data_i`;
    - set `cnt` to LATENCY-1;
    - go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - If `cnt`==0, go to RESP at this edge:
    - a read loads `data_o` with the addressed lane;
    - a write stores the latched data into the array.
  - Otherwise decrement `cnt`.
  - Request inputs are not sampled in WAIT.
- **RESP**
  - `data_rdy_o` = 1.
  - Go unconditionally to IDLE at the next edge. Request inputs are not sampled in RESP.
- **Simultaneous `rd_req_i` and `wr_req_i` in IDLE:** the write wins and the read is dropped.
- **`data_o`**
  - Holds the last read lane until the next read completes.
  - Write transactions never change `data_o`.
- **Requestor contract**
  - The requestor holds its request and operands stable until it sees `data_rdy_o`, then deasserts the request on the same edge.
  - A request still high when the FSM returns to IDLE is taken as a new transaction.
- **Reset asserted at any time**
  - State goes to IDLE, `cnt` to 0, `data_rdy_o`/`busy_o`/`data_o` to 0.
  - An in-flight write is abandoned, and the array is not modified.
- **Read-after-write to the same lane:** returns the new data, because the write commits before its ready pulse.

## Timing
- **Reset values:** `data_rdy_o`=0, `busy_o`=0, `data_o`=0, state IDLE.
- **Accept:** a request is accepted at edge T, and `busy_o` rises after edge T.
- **Commit:** the array write or the `data_o` update happens at edge T+LATENCY.
- **Ready pulse:** `data_rdy_o` is high exactly in the cycle between edges T+LATENCY and T+LATENCY+1, and is never high for two consecutive cycles.
- **Back-to-back:** the earliest next accept is edge T+LATENCY+2, so back-to-back throughput is one transaction per LATENCY+2 cycles.
- **`busy_o`:** high from after T through the RESP cycle inclusive.
- **LATENCY=1:** T→WAIT, T+1→RESP; the ready pulse follows edge T+1.

## Test plan
- **Reset:** hold `rsn_i`=0 for 4 cycles, with requests high.
  - Required: all outputs 0, no state change, array untouched.
- **Write then read, LATENCY=3:**
  - Write `addr_i`=0x20 (lane 2), data 128'hffeeddccbbaa99887766554433221100; the ready pulse comes exactly 3 edges after accept, and `data_o` stays 0.
  - Then read 0x2C. Required: `data_o` = the written lane in the ready cycle, and `busy_o` drops the next cycle.
- **Write/read collision:** assert `rd_req_i`=`wr_req_i`=1 at 0x30 with data 128'h1.
  - Required: write performed; a following read of 0x30 returns 128'h1, and `data_o` is unchanged by the write.
- **Wrap-around, MEM_LANES=1024:** write 128'hCAFE to lane 5, then read address 0x0000_4050.
  - Required: returns 128'hCAFE.
- **Reset mid-write:** accept a write of 128'hDEAD to lane 7, which was preloaded with 128'hBEEF, and pulse `rsn_i` low during WAIT.
  - Required: no `data_rdy_o`; a subsequent read of lane 7 returns 128'hBEEF.
- **Held request:** keep `rd_req_i` high across the ready cycle.
  - Required: a second transaction is accepted at T+LATENCY+2, and ready pulses are separated by LATENCY+2 cycles.

Source files
------------

// File: rtl/segre_main_memory.sv
// Lane-wide backing store behind segre_mmu: one read or write at a time, fixed
// LATENCY from accept to commit, completion signalled by a one-cycle ready pulse.
module segre_main_memory #(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128,
    parameter int MEM_LANES = 1024,
    parameter int LATENCY   = 5
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 rd_req_i,
    input  logic                 wr_req_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [LANE_SIZE-1:0] data_i,
    output logic                 data_rdy_o,
    output logic [LANE_SIZE-1:0] data_o,
    output logic                 busy_o
);

    localparam int OFF   = $clog2(LANE_SIZE / 8);
    localparam int IDX   = $clog2(MEM_LANES);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_wr_q, op_wr_d;
    logic [IDX-1:0]       idx_q, idx_d;
    logic [LANE_SIZE-1:0] wdata_q, wdata_d;
    logic [LANE_SIZE-1:0] rdata_q, rdata_d;
    logic                 mem_we;

    logic [LANE_SIZE-1:0] mem_q [MEM_LANES];

    // Byte-offset and upper address bits take no part in lane selection.
    logic unused_addr;
    assign unused_addr = ^{addr_i[ADDR_SIZE-1:OFF+IDX], addr_i[OFF-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req_i || rd_req_i) begin
                    op_wr_d = wr_req_i;
                    idx_d   = addr_i[OFF +: IDX];
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    // Commit happens on the edge entering RESP, so a read issued
                    // after the ready pulse always sees the new lane.
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign data_rdy_o = (state_q == RESP);
    assign busy_o     = (state_q != IDLE);
    assign data_o     = rdata_q;

endmodule

// File: tb/tb_segre_main_memory.sv
// Scoreboard bench for segre_main_memory with LATENCY=3: the driver queues the
// expected lane and ready cycle per transaction, a negedge monitor checks them.
module tb_segre_main_memory;

    localparam int LAT = 3;

    logic         clk_i = 1'b0;
    logic         rsn_i;
    logic         rd_req_i;
    logic         wr_req_i;
    logic [31:0]  addr_i;
    logic [127:0] data_i;
    logic         data_rdy_o;
    logic [127:0] data_o;
    logic         busy_o;

    segre_main_memory #(
        .ADDR_SIZE(32),
        .LANE_SIZE(128),
        .MEM_LANES(1024),
        .LATENCY  (LAT)
    ) dut (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .rd_req_i  (rd_req_i),
        .wr_req_i  (wr_req_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_rdy_o(data_rdy_o),
        .data_o    (data_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    logic [127:0] last_rd = '0;
    logic         prev_rdy = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, expv);
        end
    endtask

    // Monitor: every ready pulse must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rsn_i === 1'b1) begin
            if (data_rdy_o) begin
                check("rdy_not_double", 128'(prev_rdy), 128'd0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rdy_unexpected: got ready pulse at cycle %0d, required none", cyc);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_data", data_o, e.data);
                    check("rsp_cycle", 128'(cyc), 128'(e.cyc));
                end
            end else if (prev_rdy) begin
                check("busy_drop", 128'(busy_o), 128'd0);
            end
            prev_rdy = data_rdy_o;
        end else begin
            prev_rdy = 1'b0;
        end
    end

    task automatic wait_rdy(input string nm);
        bit found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (data_rdy_o) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready within 40 cycles, required a pulse", nm);
        end
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [127:0] wd, input logic [127:0] exp_rd, input string nm);
        exp_t e;
        @(negedge clk_i);
        rd_req_i = rd;
        wr_req_i = wr;
        addr_i   = addr;
        data_i   = wd;
        @(posedge clk_i);
        #1;
        if (!wr) last_rd = exp_rd;
        e.data = last_rd;
        e.cyc  = cyc + LAT;
        sb_q.push_back(e);
        check({nm, "_busy"}, 128'(busy_o), 128'd1);
        wait_rdy(nm);
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        rsn_i    = 1'b0;
        rd_req_i = 1'b1;
        wr_req_i = 1'b1;
        addr_i   = 32'h0000_0090;
        data_i   = '1;
        dut.mem_q[9] = 128'h99;
        dut.mem_q[7] = 128'hBEEF;

        // Reset held with both requests high
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("rst_rdy", 128'(data_rdy_o), 128'd0);
            check("rst_busy", 128'(busy_o), 128'd0);
            check("rst_data", data_o, 128'd0);
        end
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
        rsn_i    = 1'b1;
        @(negedge clk_i);
        check("idle_busy", 128'(busy_o), 128'd0);

        run_txn(1'b0, 1'b1, 32'h20, 128'hffeeddccbbaa99887766554433221100, '0, "wr_lane2");
        run_txn(1'b1, 1'b0, 32'h2C, '0, 128'hffeeddccbbaa99887766554433221100, "rd_lane2");
        run_txn(1'b1, 1'b0, 32'h90, '0, 128'h99, "rd_lane9_untouched");

        // Collision: write wins, data_o keeps the lane-9 read
        run_txn(1'b1, 1'b1, 32'h30, 128'h1, '0, "collide");
        run_txn(1'b1, 1'b0, 32'h30, '0, 128'h1, "rd_lane3");

        run_txn(1'b0, 1'b1, 32'h50, 128'hCAFE, '0, "wr_lane5");
        run_txn(1'b1, 1'b0, 32'h0000_4050, '0, 128'hCAFE, "rd_wrap");

        // Reset in the middle of a write to lane 7
        @(negedge clk_i);
        wr_req_i = 1'b1;
        addr_i   = 32'h70;
        data_i   = 128'hDEAD;
        @(posedge clk_i);
        #1;
        check("midwr_busy", 128'(busy_o), 128'd1);
        @(negedge clk_i);
        wr_req_i = 1'b0;
        rsn_i    = 1'b0;
        #1;
        check("midrst_busy", 128'(busy_o), 128'd0);
        check("midrst_data", data_o, 128'd0);
        last_rd = '0;
        @(negedge clk_i);
        rsn_i = 1'b1;
        repeat (LAT + 3) @(negedge clk_i);
        run_txn(1'b1, 1'b0, 32'h70, '0, 128'hBEEF, "rd_lane7_kept");

        // Held read: second accept at T+LAT+2
        @(negedge clk_i);
        rd_req_i = 1'b1;
        addr_i   = 32'h70;
        @(posedge clk_i);
        #1;
        e.data = 128'hBEEF;
        e.cyc  = cyc + LAT;
        sb_q.push_back(e);
        e.cyc  = cyc + 2 * LAT + 2;
        sb_q.push_back(e);
        last_rd = 128'hBEEF;
        wait_rdy("held_first");
        wait_rdy("held_second");
        rd_req_i = 1'b0;

        repeat (LAT + 4) @(negedge clk_i);
        check("sb_empty", 128'(sb_q.size()), 128'd0);
        check("end_busy", 128'(busy_o), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required completion");
        $fatal(1);
    end

endmodule
